// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: frame geometry, receiver state codes (also the LED
// status codes) and the host/device command bytes used with PS2_send.
package ps2_pkg;

    localparam int PS2_FRAME_BITS = 11;
    localparam int PS2_DATA_W     = 8;

    localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
    localparam logic [7:0] PS2_RSP_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RSP_BAT    = 8'hAA;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_DATA   = 4'd1,
        ST_PARITY = 4'd2,
        ST_STOP   = 4'd3,
        ST_DONE   = 4'd4
    } ps2_state_e;

    // Odd parity: the data bits plus the parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [PS2_DATA_W-1:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_receive_if.sv
// Result bundle of the PS/2 receiver: received byte, strobes, error flags and debug status.
interface ps2_receive_if;
    import ps2_pkg::*;

    logic [PS2_DATA_W-1:0] data;
    logic                  valid;
    logic                  err_parity;
    logic                  err_frame;
    logic                  err_timeout;
    logic                  busy;
    logic [3:0]            status;

    modport master (
        output data, valid, err_parity, err_frame, err_timeout, busy, status
    );

    modport slave (
        input data, valid, err_parity, err_frame, err_timeout, busy, status
    );

endinterface

// File: rtl/ps2_clk_filter.sv
// PS2C conditioning: 2-FF synchronizer, FILTER_LEN-sample debounce and a
// one-cycle strobe on each filtered 1->0 transition.
module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic qzt_clk,
    input  logic rst_n,
    input  logic in,
    output logic level,
    output logic fall
);

    logic [1:0] sync;
    logic [7:0] cnt;

    // cnt counts consecutive synchronized samples that disagree with level.
    always_ff @(posedge qzt_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= 2'b11;
            level <= 1'b1;
            cnt   <= 8'd0;
            fall  <= 1'b0;
        end else begin
            sync <= {sync[0], in};
            fall <= 1'b0;
            if (sync[1] != level) begin
                if (cnt == 8'(FILTER_LEN - 1)) begin
                    level <= sync[1];
                    cnt   <= 8'd0;
                    fall  <= level;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end else begin
                cnt <= 8'd0;
            end
        end
    end

endmodule

// File: rtl/ps2_receive.sv
// Device-to-host PS/2 frame receiver: start, 8 data bits LSB first, odd
// parity, stop; reports each byte or error with registered one-cycle pulses.
module ps2_receive
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100_000,
    parameter int DATA_W      = 8
) (
    input  logic          qzt_clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          PS2C,
    input  logic          PS2D,
    ps2_receive_if.master rx
);

    localparam int          BW       = $clog2(DATA_W);
    localparam logic [19:0] TMO_LAST = 20'(TIMEOUT_CYC - 1);

    ps2_state_e        state, state_nx;
    logic [1:0]        d_sync;
    logic              d_s;
    logic              clk_level;
    logic              fall;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic              par_bit;
    logic              stop_bit;
    logic [19:0]       tmo_cnt;
    logic              in_frame;
    logic              tmo_hit;
    logic              par_ok;

    logic [DATA_W-1:0] data_q;
    logic              valid_q, err_par_q, err_frm_q, err_tmo_q;

    ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .qzt_clk (qzt_clk),
        .rst_n   (rst_n),
        .in      (PS2C),
        .level   (clk_level),
        .fall    (fall)
    );

    always_ff @(posedge qzt_clk or negedge rst_n) begin
        if (!rst_n) d_sync <= 2'b11;
        else        d_sync <= {d_sync[0], PS2D};
    end
    assign d_s = d_sync[1];

    assign in_frame = (state == ST_DATA) || (state == ST_PARITY) || (state == ST_STOP);
    // A strobe in the same cycle as the limit still counts as a live bit.
    assign tmo_hit  = enable && in_frame && !fall && (tmo_cnt == TMO_LAST);
    assign par_ok   = odd_parity_ok(shreg, par_bit);

    always_ff @(posedge qzt_clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (!enable) begin
            state_nx = ST_IDLE;
        end else if (tmo_hit) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (fall && !d_s) state_nx = ST_DATA;
                ST_DATA:   if (fall && bit_cnt == BW'(DATA_W - 1)) state_nx = ST_PARITY;
                ST_PARITY: if (fall) state_nx = ST_STOP;
                ST_STOP:   if (fall) state_nx = ST_DONE;
                ST_DONE:   state_nx = ST_IDLE;
                default:   state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge qzt_clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            stop_bit  <= 1'b0;
            tmo_cnt   <= 20'd0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            err_par_q <= 1'b0;
            err_frm_q <= 1'b0;
            err_tmo_q <= 1'b0;
        end else begin
            valid_q   <= 1'b0;
            err_par_q <= 1'b0;
            err_frm_q <= 1'b0;
            err_tmo_q <= 1'b0;
            if (!enable) begin
                bit_cnt <= '0;
                tmo_cnt <= 20'd0;
            end else begin
                if (fall || !in_frame || tmo_hit) tmo_cnt <= 20'd0;
                else                              tmo_cnt <= tmo_cnt + 20'd1;

                if (tmo_hit) begin
                    shreg     <= '0;
                    bit_cnt   <= '0;
                    err_tmo_q <= 1'b1;
                end else if (fall) begin
                    case (state)
                        ST_IDLE: begin
                            bit_cnt <= '0;
                            shreg   <= '0;
                        end
                        ST_DATA: begin
                            shreg   <= {d_s, shreg[DATA_W-1:1]};
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                        ST_PARITY: par_bit  <= d_s;
                        ST_STOP:   stop_bit <= d_s;
                        default: ;
                    endcase
                end

                if (state == ST_DONE) begin
                    if (par_ok && stop_bit) data_q <= shreg;
                    valid_q   <= par_ok && stop_bit;
                    err_par_q <= !par_ok;
                    err_frm_q <= !stop_bit;
                end
            end
        end
    end

    assign rx.data        = data_q;
    assign rx.valid       = valid_q;
    assign rx.err_parity  = err_par_q;
    assign rx.err_frame   = err_frm_q;
    assign rx.err_timeout = err_tmo_q;
    assign rx.busy        = (state != ST_IDLE);
    assign rx.status      = state;

endmodule

// File: doc/ps2_receive.md
Name: ps2_receive

Overview:
- Device-to-host PS/2 receiver that sits alongside PS2_send on the same PS2C/PS2D pair.
- Consumes the frames the mouse produces after a host command, e.g. the 0xFA ACK and the movement packets.
- Samples the open-collector lines and recovers 11-bit frames: start, 8 data bits LSB first, odd parity, stop.
- Presents each byte with a one-cycle valid strobe plus error flags; the downstream mouse-packet logic and the LED debug outputs consume it.

Parameters:
- FILTER_LEN, 8: consecutive identical qzt_clk samples required before the filtered PS2C level changes (1..255).
- TIMEOUT_CYC, 100_000: qzt_clk cycles allowed between PS2C falling edges inside a frame (2 ms at 50 MHz). Width 20 bits.
- DATA_W, 8: payload width. Fixed at 8; exists only for the shared package.

Ports:
- qzt_clk  in  1  50 MHz system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  high = receive allowed. Tie to NOT(PS2_send busy) so the receiver ignores host-driven traffic.
- PS2C  in  1  PS/2 clock line, sampled only and never driven here (the top level owns the inout).
- PS2D  in  1  PS/2 data line, sampled only.
- data  out  8  last good byte. Holds its value until the next good frame.
- valid  out  1  one-cycle pulse when data is updated.
- err_parity  out  1  one-cycle pulse: parity check failed.
- err_frame  out  1  one-cycle pulse: stop bit read 0.
- err_timeout  out  1  one-cycle pulse: frame abandoned on a bit-gap timeout.
- busy  out  1  high while the FSM is not IDLE.
- status  out  4  debug code for the LEDs: 0 IDLE, 1 DATA, 2 PARITY, 3 STOP, 4 DONE.

Behaviour:
- Reset (async, rst_n=0) values:
  - data=8'h00; valid, err_*, busy = 0; status=0.
  - FSM in IDLE; bit counter, shift register, timeout counter = 0.
  - Filter state and synchronizers = 1 (idle-high lines).
- Input conditioning:
  - PS2C and PS2D each pass through a 2-FF synchronizer.
  - The synchronized PS2C feeds the filter; the filtered level changes only after FILTER_LEN consecutive equal samples.
  - A sample strobe fires for one cycle when the filtered PS2C goes 1->0.
  - Synchronized PS2D is captured in the strobe cycle.
- FSM, advancing only on strobe unless stated otherwise:
  - IDLE: a strobe with PS2D=0 (start bit) -> DATA, bit counter=0. A strobe with PS2D=1 is ignored and no flag is raised.
  - DATA: shift in LSB first. After the 8th bit (counter 7) -> PARITY.
  - PARITY: capture the parity bit -> STOP.
  - STOP: capture the stop bit -> DONE.
  - DONE: lasts exactly one cycle, then -> IDLE.
- Result evaluation in DONE:
  - Parity is good when XOR of the 8 data bits and the parity bit = 1.
  - Parity good and stop=1: data <= shifted byte, valid=1.
  - Parity bad: err_parity=1.
  - Stop=0: err_frame=1.
  - Both may pulse in the same cycle. data is unchanged on any error.
- Latency: valid/err outputs are registered and high in the cycle after DONE, i.e. 2 qzt_clk cycles after the stop-bit strobe.
- Timeout:
  - The counter clears on every strobe and increments in states DATA, PARITY and STOP.
  - Reaching TIMEOUT_CYC -> IDLE, err_timeout pulses for one cycle, and the partial byte is discarded.
- enable=0:
  - Synchronously forces IDLE and clears the counters.
  - No flags are raised and data is retained.
  - Strobes are ignored while enable is low.
  - When enable rises mid-traffic, reception resumes only at the next start bit seen in IDLE.
- A strobe arriving in DONE is impossible at legal PS/2 rates. If it occurs it is dropped.
- Reset asserted mid-frame aborts the frame immediately with no flag pulses.

Decomposition:
- Package ps2_pkg:
  - FSM state encoding, reused as the status codes 0..4.
  - PS2_FRAME_BITS=11, PS2_DATA_W=8.
  - Shared command/response constants such as 8'hFA ACK and 8'hFF reset, used with PS2_send.
- Sub-module ps2_clk_filter: 2-FF synchronizer plus the FILTER_LEN debounce plus falling-edge strobe generator, with ports qzt_clk, rst_n, in, level, fall.

Test Plan:
- All scenarios run with FILTER_LEN=4, TIMEOUT_CYC=10_000 and a PS2C period of 4000 cycles (80 µs); data changes mid-high phase.
- Good frame: 0,0xFA LSB first (0,1,0,1,1,1,1,1), parity 1, stop 1 -> one valid pulse 2 cycles after the stop-bit edge, data=8'hFA, no err_*.
- Parity error: 0x08 sent with parity 1 -> err_parity pulse, valid=0, data still 8'hFA. Then 0x08 with parity 0 -> valid, data=8'h08.
- Frame error: 0xFF, parity 1, stop 0 -> err_frame only; busy falls the cycle after DONE.
- Timeout and glitch:
  - Stop PS2C high after 5 data bits -> err_timeout exactly 10_000 cycles after the last edge; FSM in IDLE.
  - A following good frame 0x00 (parity 1) -> data=8'h00.
  - A 2-cycle low glitch on PS2C mid-frame -> no extra strobe; the byte is received correctly.
- Enable/reset:
  - Drop enable after 3 bits, re-raise it, send 0x5A (parity 1) -> no flags, then valid with data=8'h5A.
  - Pulse rst_n low mid-frame -> all outputs 0 immediately and data=8'h00.
